// File: rtl/command_input_unit_if.sv
// Signal bundle between the raw operator panel / controller side and the command input unit.
// Names match the controller-facing port list so the wiring reads one-to-one.
interface command_input_unit_if;
    logic       i_btn_load;
    logic       i_btn_comp;
    logic       i_btn_clr;
    logic [2:0] i_sw_op;
    logic       i_busy;
    logic       o_LOAD;
    logic       o_COMP;
    logic       o_CLR;
    logic [2:0] o_OP;
    logic       o_pending;
    logic       o_cmd_drop;

    modport slave (
        input  i_btn_load, i_btn_comp, i_btn_clr, i_sw_op, i_busy,
        output o_LOAD, o_COMP, o_CLR, o_OP, o_pending, o_cmd_drop
    );

    modport master (
        output i_btn_load, i_btn_comp, i_btn_clr, i_sw_op, i_busy,
        input  o_LOAD, o_COMP, o_CLR, o_OP, o_pending, o_cmd_drop
    );
endinterface

// File: rtl/command_input_unit.sv
// Button front end for the ALP controller: synchronise, debounce, edge-detect, then
// arbitrate LOAD/COMP/CLR into single-cycle commands, holding one while the controller is busy.
module command_input_unit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic                 clk,
    input  logic                 i_rst,
    command_input_unit_if.slave  cmd
);
    localparam int               NB       = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_GUARD} state_t;

    // Bit order everywhere below: 0 = LOAD, 1 = COMP, 2 = CLR
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_meta_q;
    logic [NB-1:0] btn_sync_q;
    logic [2:0]    op_meta_q;
    logic [2:0]    op_sync_q;
    logic [NB-1:0] req_vec;

    assign btn_raw = {cmd.i_btn_clr, cmd.i_btn_comp, cmd.i_btn_load};

    always_ff @(posedge clk) begin
        if (i_rst) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            op_meta_q  <= '0;
            op_sync_q  <= '0;
        end else begin
            btn_meta_q <= btn_raw;
            btn_sync_q <= btn_meta_q;
            op_meta_q  <= cmd.i_sw_op;
            op_sync_q  <= op_meta_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_q;
            logic             stable_q;
            logic             req_q;

            // The request is registered on the same edge the stable level rises.
            always_ff @(posedge clk) begin
                if (i_rst) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                    req_q    <= 1'b0;
                end else begin
                    req_q <= 1'b0;
                    if (btn_sync_q[gi] == stable_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q    <= '0;
                        stable_q <= btn_sync_q[gi];
                        req_q    <= btn_sync_q[gi];
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end

            assign req_vec[gi] = req_q;
        end
    endgenerate

    logic req_load, req_comp, req_clr;
    logic win_load, win_comp, win_any;

    assign req_load = req_vec[0];
    assign req_comp = req_vec[1];
    assign req_clr  = req_vec[2];
    assign win_load = req_load & ~req_clr;
    assign win_comp = req_comp & ~req_clr & ~req_load;
    assign win_any  = win_load | win_comp;

    state_t     state_q, state_d;
    logic       pend_comp_q, pend_comp_d;
    logic [2:0] op_hold_q, op_hold_d;
    logic [2:0] op_q, op_d;
    logic       load_q, load_d;
    logic       comp_q, comp_d;
    logic       clr_q, clr_d;
    logic       drop_q, drop_d;

    always_comb begin
        state_d     = state_q;
        pend_comp_d = pend_comp_q;
        op_hold_d   = op_hold_q;
        op_d        = op_q;
        load_d      = 1'b0;
        comp_d      = 1'b0;
        clr_d       = 1'b0;
        drop_d      = (req_clr & (req_load | req_comp)) | (req_load & req_comp);

        // A COMP arriving while a command is already held is dropped, so it must not touch op_hold
        if (win_comp && state_q != S_PEND) begin
            op_hold_d = op_sync_q;
        end

        if (req_clr) begin
            clr_d       = 1'b1;
            state_d     = S_IDLE;
            pend_comp_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_any) begin
                        if (!cmd.i_busy) begin
                            load_d  = win_load;
                            comp_d  = win_comp;
                            if (win_comp) begin
                                op_d = op_sync_q;
                            end
                            state_d = S_GUARD;
                        end else begin
                            pend_comp_d = win_comp;
                            state_d     = S_PEND;
                        end
                    end
                end
                S_PEND: begin
                    if (win_any) begin
                        drop_d = 1'b1;
                    end
                    if (!cmd.i_busy) begin
                        load_d  = ~pend_comp_q;
                        comp_d  = pend_comp_q;
                        if (pend_comp_q) begin
                            op_d = op_hold_q;
                        end
                        state_d = S_GUARD;
                    end
                end
                S_GUARD: begin
                    // i_busy may not yet reflect the command just issued, so hold anything new
                    if (win_any) begin
                        pend_comp_d = win_comp;
                        state_d     = S_PEND;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            pend_comp_q <= 1'b0;
            op_hold_q   <= '0;
            op_q        <= '0;
            load_q      <= 1'b0;
            comp_q      <= 1'b0;
            clr_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_comp_q <= pend_comp_d;
            op_hold_q   <= op_hold_d;
            op_q        <= op_d;
            load_q      <= load_d;
            comp_q      <= comp_d;
            clr_q       <= clr_d;
            drop_q      <= drop_d;
        end
    end

    assign cmd.o_LOAD     = load_q;
    assign cmd.o_COMP     = comp_q;
    assign cmd.o_CLR      = clr_q;
    assign cmd.o_OP       = op_q;
    assign cmd.o_pending  = (state_q == S_PEND);
    assign cmd.o_cmd_drop = drop_q;
endmodule

// File: tb/tb_command_input_unit.sv
// Directed bench for command_input_unit with DEBOUNCE_CYCLES = 4: latency, glitch rejection,
// busy holding, drops, CLR override, arbitration, guard cycle and reset mid-debounce.
module tb_command_input_unit;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic i_rst;

    command_input_unit_if ifc();

    command_input_unit #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (3)
    ) dut (
        .clk  (clk),
        .i_rst(i_rst),
        .cmd  (ifc)
    );

    always #5 clk = ~clk;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int n_load = 0, n_comp = 0, n_clr = 0, n_drop = 0, n_overlap = 0, n_op_bad = 0;
    int base_load, base_comp, base_clr, base_drop;
    logic [2:0] prev_op;

    // Pulse counters and invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (ifc.o_LOAD)     n_load++;
        if (ifc.o_COMP)     n_comp++;
        if (ifc.o_CLR)      n_clr++;
        if (ifc.o_cmd_drop) n_drop++;
        if (32'(ifc.o_LOAD) + 32'(ifc.o_COMP) + 32'(ifc.o_CLR) > 1) n_overlap++;
        if (!i_rst && ifc.o_OP !== prev_op && ifc.o_COMP !== 1'b1) n_op_bad++;
        prev_op = ifc.o_OP;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("chk %s: got=%0d ok", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap_base();
        base_load = n_load;
        base_comp = n_comp;
        base_clr  = n_clr;
        base_drop = n_drop;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_load"}, ifc.o_LOAD, 0);
        chk({tag, "_comp"}, ifc.o_COMP, 0);
        chk({tag, "_clr"},  ifc.o_CLR, 0);
        chk({tag, "_op"},   ifc.o_OP, 0);
        chk({tag, "_pend"}, ifc.o_pending, 0);
        chk({tag, "_drop"}, ifc.o_cmd_drop, 0);
    endtask

    initial begin
        i_rst          = 1'b1;
        ifc.i_btn_load = 1'b0;
        ifc.i_btn_comp = 1'b0;
        ifc.i_btn_clr  = 1'b0;
        ifc.i_sw_op    = 3'b111;
        ifc.i_busy     = 1'b0;
        tick(3);
        chk_all_zero("reset");

        ifc.i_sw_op = 3'b000;
        i_rst       = 1'b0;
        tick(8);

        // 3-sample glitch is one short of the debounce window
        ifc.i_btn_comp = 1'b1;
        tick(3);
        ifc.i_btn_comp = 1'b0;
        tick(12);
        chk("glitch_comp", n_comp, 0);
        chk("glitch_drop", n_drop, 0);

        // Clean press: first sampling edge k, o_COMP registered at k+6
        ifc.i_btn_comp = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick(1);
            chk($sformatf("press_lat%0d", c), ifc.o_COMP, (c == 7));
            if (c == 7) chk("press_op", ifc.o_OP, 3'b000);
        end
        tick(12);
        ifc.i_btn_comp = 1'b0;
        tick(12);
        chk("press_once", n_comp, 1);

        // COMP while busy, then release busy
        ifc.i_sw_op = 3'b010;
        ifc.i_busy  = 1'b1;
        tick(4);
        ifc.i_btn_comp = 1'b1;
        tick(7);
        chk("busy_no_comp", ifc.o_COMP, 0);
        chk("busy_pend", ifc.o_pending, 1);
        ifc.i_btn_comp = 1'b0;
        tick(3);
        chk("busy_hold", ifc.o_pending, 1);
        chk("busy_op_old", ifc.o_OP, 3'b000);
        ifc.i_busy = 1'b0;
        tick(1);
        chk("rel_comp", ifc.o_COMP, 1);
        chk("rel_op", ifc.o_OP, 3'b010);
        chk("rel_pend", ifc.o_pending, 0);
        tick(1);
        chk("rel_once", ifc.o_COMP, 0);
        tick(12);

        // LOAD while a COMP is pending is dropped
        snap_base();
        ifc.i_sw_op = 3'b001;
        ifc.i_busy  = 1'b1;
        tick(4);
        ifc.i_btn_comp = 1'b1;
        tick(8);
        chk("p2_pend", ifc.o_pending, 1);
        ifc.i_btn_comp = 1'b0;
        ifc.i_sw_op    = 3'b100;
        ifc.i_btn_load = 1'b1;
        tick(6);
        chk("p2_nodrop", ifc.o_cmd_drop, 0);
        tick(1);
        chk("p2_drop", ifc.o_cmd_drop, 1);
        tick(1);
        chk("p2_drop_end", ifc.o_cmd_drop, 0);
        chk("p2_still_pend", ifc.o_pending, 1);
        ifc.i_btn_load = 1'b0;
        tick(8);
        ifc.i_busy = 1'b0;
        tick(1);
        chk("p2_comp", ifc.o_COMP, 1);
        chk("p2_op", ifc.o_OP, 3'b001);
        chk("p2_load", ifc.o_LOAD, 0);
        tick(12);
        chk("p2_load_cnt", n_load - base_load, 0);
        chk("p2_comp_cnt", n_comp - base_comp, 1);
        chk("p2_drop_cnt", n_drop - base_drop, 1);

        // CLR overrides busy and empties the pending slot
        snap_base();
        ifc.i_sw_op = 3'b011;
        ifc.i_busy  = 1'b1;
        tick(4);
        ifc.i_btn_comp = 1'b1;
        tick(8);
        chk("clr_pre_pend", ifc.o_pending, 1);
        ifc.i_btn_comp = 1'b0;
        ifc.i_btn_clr  = 1'b1;
        tick(6);
        chk("clr_wait", ifc.o_CLR, 0);
        tick(1);
        chk("clr_pulse", ifc.o_CLR, 1);
        chk("clr_unpend", ifc.o_pending, 0);
        chk("clr_op", ifc.o_OP, 3'b001);
        ifc.i_btn_clr = 1'b0;
        tick(4);
        ifc.i_busy = 1'b0;
        tick(12);
        chk("clr_no_comp", n_comp - base_comp, 0);
        chk("clr_cnt", n_clr - base_clr, 1);
        chk("clr_no_drop", n_drop - base_drop, 0);

        // LOAD and COMP stable together: LOAD wins, COMP dropped
        snap_base();
        ifc.i_sw_op = 3'b110;
        tick(4);
        ifc.i_btn_load = 1'b1;
        ifc.i_btn_comp = 1'b1;
        tick(7);
        chk("sim_load", ifc.o_LOAD, 1);
        chk("sim_comp", ifc.o_COMP, 0);
        chk("sim_drop", ifc.o_cmd_drop, 1);
        ifc.i_btn_load = 1'b0;
        ifc.i_btn_comp = 1'b0;
        tick(12);
        chk("sim_load_cnt", n_load - base_load, 1);
        chk("sim_comp_cnt", n_comp - base_comp, 0);
        chk("sim_drop_cnt", n_drop - base_drop, 1);

        // COMP request lands in the guard cycle after a LOAD
        snap_base();
        ifc.i_btn_load = 1'b1;
        tick(1);
        ifc.i_btn_comp = 1'b1;
        tick(6);
        chk("g_load", ifc.o_LOAD, 1);
        tick(1);
        chk("g_pend", ifc.o_pending, 1);
        chk("g_nocomp", ifc.o_COMP, 0);
        tick(1);
        chk("g_comp", ifc.o_COMP, 1);
        chk("g_op", ifc.o_OP, 3'b110);
        chk("g_pend_clear", ifc.o_pending, 0);
        ifc.i_btn_load = 1'b0;
        ifc.i_btn_comp = 1'b0;
        tick(12);
        chk("g_drop_cnt", n_drop - base_drop, 0);

        // Reset mid-debounce with LOAD held through it
        ifc.i_btn_load = 1'b1;
        tick(3);
        i_rst = 1'b1;
        tick(2);
        chk_all_zero("rst_mid");
        i_rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick(1);
            chk($sformatf("rst_lat%0d", c), ifc.o_LOAD, (c == 7));
        end
        ifc.i_btn_load = 1'b0;
        tick(12);

        chk("no_overlap", n_overlap, 0);
        chk("op_only_with_comp", n_op_bad, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule

// File: doc/command_input_unit.md
# command_input_unit

Front-end stage directly upstream of the ALP controller. It turns the raw LOAD/COMP/CLR push-buttons and the 3-bit OP switches into clean, single-cycle command pulses and a stable opcode for the controller. It performs synchronisation, debouncing and edge detection, and holds commands while the controller is busy in a multi-cycle operation (MUL/DIV). Outputs drive the controller's `i_LOAD`, `i_COMP`, `i_CLR` and `i_OP` directly.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised samples required to accept a new button level (min 2).
- `CNT_W`, default 5: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk`  in  1  system clock, all logic on rising edge.
- `i_rst`  in  1  reset: synchronous, active-high.
- `i_btn_load`  in  1  raw LOAD button, asynchronous, active-high.
- `i_btn_comp`  in  1  raw COMP button, asynchronous, active-high.
- `i_btn_clr`  in  1  raw CLR button, asynchronous, active-high.
- `i_sw_op`  in  3  raw OP switches, asynchronous.
- `i_busy`  in  1  controller state is not IDLE (registered in controller).
- `o_LOAD`  out  1  one-cycle load command.
- `o_COMP`  out  1  one-cycle compute command.
- `o_CLR`  out  1  one-cycle clear command.
- `o_OP`  out  3  opcode, registered, stable between COMP requests.
- `o_pending`  out  1  a LOAD/COMP is held waiting for `!i_busy`.
- `o_cmd_drop`  out  1  one-cycle pulse: a request was discarded.

## Operation
- **Synchroniser.** There is a 2-flop synchroniser on each button and each OP bit.
- **Debounce.** Each button has its own debouncer. It has a stable level register and a CNT_W counter. The counter increments while the synchronised level differs from the stable level, and zeroes when they are equal. When the count reaches DEBOUNCE_CYCLES-1 while still differing, the stable level flips and the counter zeroes.
- **Edge detect.** A 0→1 transition of a stable level forms a one-cycle request: `req_load`, `req_comp` or `req_clr`.
- **Opcode capture.** On `req_comp`, the synchronised OP is captured into `op_hold`. `op_hold` is written to `o_OP` when that COMP is issued.
- **Priority.** Simultaneous requests in the same cycle resolve as CLR > LOAD > COMP. Each losing request pulses `o_cmd_drop` once per cycle.
- **CLR handling.**
  - CLR is never held. Its request registers `o_CLR` = 1 for the next cycle regardless of `i_busy` or FSM state.
  - CLR also clears the pending slot and returns the FSM to S_IDLE.
  - A held command removed by CLR does not pulse `o_cmd_drop`.
- **FSM** (registered):
  - S_IDLE:
    - request and `!i_busy` → issue (next-cycle `o_LOAD`/`o_COMP` = 1) → S_GUARD.
    - request and `i_busy` → store type in pending slot → S_PEND.
  - S_PEND:
    - `o_pending` = 1.
    - On the first cycle with `!i_busy`, issue the held command → S_GUARD.
    - A new LOAD/COMP request here is discarded and pulses `o_cmd_drop`.
  - S_GUARD:
    - Exactly one cycle. It covers the controller's registered `i_busy` lag.
    - Any LOAD/COMP request in this cycle is stored as pending → S_PEND.
    - Otherwise → S_IDLE.
- **Output width.** `o_LOAD`, `o_COMP` and `o_CLR` are each high for exactly one cycle per accepted command, and are never high together.
- **Release.** Button release (1→0) generates nothing.

## Timing
- **Reset values.** On `i_rst`, at the next edge:
  - all outputs = 0, `o_OP` = 3'b000;
  - stable levels = 0, counters = 0, synchronisers = 0;
  - pending slot empty, FSM = S_IDLE.
- **Reset mid-operation.** Reset mid-debounce or mid-pending discards all in-flight state. A button held through reset registers a press DEBOUNCE_CYCLES+3 cycles after `i_rst` falls.
- **Latency.** A raw button rises before edge k and stays high. The request is formed at edge k+DEBOUNCE_CYCLES+1, and the command output is high for the cycle after edge k+DEBOUNCE_CYCLES+2, when the FSM is idle and not busy.
- **Glitch rejection.** Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no output.
- **Pending release.** A pending command issues one cycle after the first edge that samples `i_busy` = 0.
- **`o_OP` stability.** `o_OP` changes only in the same cycle that `o_COMP` rises, then holds. Switch changes without COMP never reach `o_OP`.
- **Drop pulse.** `o_cmd_drop` is registered and appears one cycle after the discarded request.

## Test plan
- **Glitch and clean press.** DEBOUNCE_CYCLES = 4. A 3-cycle high glitch on `i_btn_comp` → no output. A clean press held 20 cycles with `i_sw_op` = 3'b000 → one `o_COMP` pulse exactly 7 cycles after the rise, with `o_OP` = 3'b000.
- **COMP while busy.** `i_sw_op` = 3'b010, press COMP while `i_busy` = 1 → `o_pending` = 1. Drop `i_busy` at edge n → `o_COMP` high in cycle n+1, `o_OP` = 3'b010, `o_pending` = 0.
- **Second request while pending.** A LOAD request while a COMP is pending → one `o_cmd_drop` pulse. Only the original COMP is issued after `i_busy` falls.
- **CLR during pending.** CLR pressed while a COMP is pending and `i_busy` = 1 → `o_CLR` pulse despite busy, `o_pending` → 0. No COMP is issued after `i_busy` falls.
- **Simultaneous presses.** LOAD and COMP become stable in the same cycle → `o_LOAD` only, plus one `o_cmd_drop`. A COMP pressed during the S_GUARD cycle goes pending, then issues when `i_busy` stays 0.
- **Reset during debounce.** Assert `i_rst` mid-debounce with the button held → all outputs 0. Press registered DEBOUNCE_CYCLES+3 cycles after reset release.
